// File: rtl/myo_spi_pkg.sv
// myo_spi_pkg
// Shared definitions for the myo SPI bus arbiter: FSM state encoding,
// motor index width and the watchdog width helper.
package myo_spi_pkg;

   localparam int MOTOR_IDX_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_WAIT_LOW  = 3'd2,
      ST_WAIT_HIGH = 3'd3,
      ST_RELEASE   = 3'd4
   } arb_state_t;

   // Watchdog width able to hold the value cycles.
   function automatic int timeout_w(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/myo_spi_bus_arbiter_rr.sv
// rr_arbiter
// Combinational round-robin pick. Requests at or above the pointer win
// first; if none are pending there, the search wraps to index 0.
// Ports:
//   req   in  N      request vector
//   ptr   in  PTR_W  index with highest priority this round
//   sel   out N      one-hot selection (zero when no request)
//   valid out 1      any request pending
module rr_arbiter #(
   parameter int N     = 2,
   parameter int PTR_W = 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     sel,
   output logic             valid
);

   logic [N-1:0] masked;
   logic [N-1:0] src;

   always_comb begin
      masked = '0;
      for (int i = 0; i < N; i++) begin
         masked[i] = req[i] && (i >= int'(ptr));
      end
      src = (masked != '0) ? masked : req;
      // walk downwards so the lowest set index is the last one written
      sel = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (src[i]) begin
            sel    = '0;
            sel[i] = 1'b1;
         end
      end
   end

   assign valid = |req;

endmodule

// File: rtl/myo_spi_bus_arbiter.sv
// myo_spi_bus_arbiter
// Shares one SpiControl/spi_master pair between NUM_REQ requesters. One
// frame per grant, round-robin order, per-frame watchdog, per-motor ss_n.
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   req, req_motor        level requests and per-requester motor index
//   grant, done, done_err one-hot grant, end-of-frame pulse, error flag
//   spi_start, spi_reset  pulses towards SpiControl/spi_master
//   spi_done, ss_n        frame engine status and frame slave select
//   motor_sel, ss_n_o     latched motor index and routed slave selects
//   busy                  not idle
//   timeout_count         saturating timed-out frame counter
//   frame_count           wrapping completed frame counter
//
// state      | meaning
// -----------+-------------------------------------------------------
// IDLE       | arbitrate; latch grantee and motor index
// START      | spi_start pulse; watchdog loaded
// WAIT_LOW   | wait for spi_done to fall (frame engine accepted)
// WAIT_HIGH  | wait for spi_done to rise (frame finished)
// RELEASE    | done pulse to grantee; advance round-robin pointer
module myo_spi_bus_arbiter
   import myo_spi_pkg::*;
#(
   parameter int NUM_REQ          = 2,
   parameter int NUMBER_OF_MOTORS = 6,
   parameter int TIMEOUT_CYCLES   = 5000
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [8*NUM_REQ-1:0]        req_motor,
   output logic [NUM_REQ-1:0]          grant,
   output logic [NUM_REQ-1:0]          done,
   output logic                        done_err,
   output logic                        spi_start,
   output logic [MOTOR_IDX_W-1:0]      motor_sel,
   input  logic                        spi_done,
   input  logic                        ss_n,
   output logic                        spi_reset,
   output logic [NUMBER_OF_MOTORS-1:0] ss_n_o,
   output logic                        busy,
   output logic [15:0]                 timeout_count,
   output logic [31:0]                 frame_count
);

   localparam int TO_W  = timeout_w(TIMEOUT_CYCLES);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   // loaded with one less so the watchdog hits zero exactly TIMEOUT_CYCLES
   // cycles after the start pulse
   localparam logic [TO_W-1:0] WDOG_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

   arb_state_t state_q, state_d;

   logic [NUM_REQ-1:0]     grant_q;
   logic [PTR_W-1:0]       idx_q;
   logic [PTR_W-1:0]       ptr_q;
   logic                   err_q;
   logic [MOTOR_IDX_W-1:0] motor_sel_q;
   logic [TO_W-1:0]        wdog_q;
   logic [15:0]            timeout_count_q;
   logic [31:0]            frame_count_q;

   logic [NUM_REQ-1:0]     pick_sel;
   logic                   pick_valid;
   logic [PTR_W-1:0]       pick_idx;
   logic [MOTOR_IDX_W-1:0] pick_motor;
   logic                   pick_bad;

   logic latch_pick;
   logic timed_out;
   logic finish;
   logic wdog_zero;

   rr_arbiter #(
      .N     (NUM_REQ),
      .PTR_W (PTR_W)
   ) u_rr (
      .req   (req),
      .ptr   (ptr_q),
      .sel   (pick_sel),
      .valid (pick_valid)
   );

   always_comb begin
      pick_idx   = '0;
      pick_motor = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_sel[i]) begin
            pick_idx   = PTR_W'(i);
            pick_motor = req_motor[MOTOR_IDX_W*i +: MOTOR_IDX_W];
         end
      end
   end

   assign pick_bad  = (pick_motor >= MOTOR_IDX_W'(NUMBER_OF_MOTORS));
   assign wdog_zero = (wdog_q == '0);

   always_comb begin
      state_d    = state_q;
      spi_start  = 1'b0;
      spi_reset  = 1'b0;
      done       = '0;
      done_err   = 1'b0;
      latch_pick = 1'b0;
      timed_out  = 1'b0;
      finish     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               latch_pick = 1'b1;
               // a bad motor index never reaches the bus
               state_d    = pick_bad ? ST_RELEASE : ST_START;
            end
         end
         ST_START: begin
            spi_start = 1'b1;
            state_d   = ST_WAIT_LOW;
         end
         ST_WAIT_LOW: begin
            // a low seen on the expiry cycle is not a rise, so expiry wins
            if (wdog_zero) begin
               spi_reset = 1'b1;
               timed_out = 1'b1;
               state_d   = ST_RELEASE;
            end else if (!spi_done) begin
               state_d = ST_WAIT_HIGH;
            end
         end
         ST_WAIT_HIGH: begin
            // the rise is checked first: rise and expiry together is success
            if (spi_done) begin
               state_d = ST_RELEASE;
            end else if (wdog_zero) begin
               spi_reset = 1'b1;
               timed_out = 1'b1;
               state_d   = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            done     = grant_q;
            done_err = err_q;
            finish   = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         grant_q         <= '0;
         idx_q           <= '0;
         ptr_q           <= '0;
         err_q           <= 1'b0;
         motor_sel_q     <= '0;
         wdog_q          <= '0;
         timeout_count_q <= '0;
         frame_count_q   <= '0;
      end else begin
         state_q <= state_d;
         if (latch_pick) begin
            grant_q     <= pick_sel;
            idx_q       <= pick_idx;
            motor_sel_q <= pick_motor;
            err_q       <= pick_bad;
         end
         if (spi_start) begin
            wdog_q <= WDOG_LOAD;
         end else if ((state_q == ST_WAIT_LOW || state_q == ST_WAIT_HIGH) && !wdog_zero) begin
            wdog_q <= wdog_q - 1'b1;
         end
         if (timed_out) begin
            err_q <= 1'b1;
            if (timeout_count_q != 16'hFFFF) begin
               timeout_count_q <= timeout_count_q + 16'd1;
            end
         end
         if (finish) begin
            grant_q       <= '0;
            frame_count_q <= frame_count_q + 32'd1;
            ptr_q         <= (idx_q == PTR_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
         end
      end
   end

   // combinational route: ss_n reaches only the addressed motor
   always_comb begin
      ss_n_o = '1;
      for (int k = 0; k < NUMBER_OF_MOTORS; k++) begin
         if (busy && motor_sel_q == MOTOR_IDX_W'(k)) begin
            ss_n_o[k] = ss_n;
         end
      end
   end

   assign busy          = (state_q != ST_IDLE);
   assign grant         = grant_q;
   assign motor_sel     = motor_sel_q;
   assign timeout_count = timeout_count_q;
   assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_myo_spi_bus_arbiter.sv
`timescale 1ns/1ps
module tb_myo_spi_bus_arbiter;

   localparam int NR = 2;
   localparam int NM = 6;
   localparam int TO = 100;

   logic          clock = 1'b0;
   logic          reset;
   logic [NR-1:0] req;
   logic [8*NR-1:0] req_motor;
   logic [NR-1:0] grant;
   logic [NR-1:0] done;
   logic          done_err;
   logic          spi_start;
   logic [7:0]    motor_sel;
   logic          spi_done;
   logic          ss_n;
   logic          spi_reset;
   logic [NM-1:0] ss_n_o;
   logic          busy;
   logic [15:0]   timeout_count;
   logic [31:0]   frame_count;

   myo_spi_bus_arbiter #(
      .NUM_REQ          (NR),
      .NUMBER_OF_MOTORS (NM),
      .TIMEOUT_CYCLES   (TO)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .req           (req),
      .req_motor     (req_motor),
      .grant         (grant),
      .done          (done),
      .done_err      (done_err),
      .spi_start     (spi_start),
      .motor_sel     (motor_sel),
      .spi_done      (spi_done),
      .ss_n          (ss_n),
      .spi_reset     (spi_reset),
      .ss_n_o        (ss_n_o),
      .busy          (busy),
      .timeout_count (timeout_count),
      .frame_count   (frame_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      int g;
      bit err;
   } exp_t;

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   // reference model state
   int m_ptr    = 0;
   int m_frames = 0;
   int m_tos    = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // scoreboard monitor: every done pulse must match the oldest expectation
   always @(negedge clock) begin
      exp_t e;
      if (!reset && done !== '0) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", done, 0);
         end else begin
            e = sb.pop_front();
            chk("done_vec", done, 64'(1) << e.g);
            chk("done_err", done_err, e.err);
         end
      end
   end

   task automatic reset_vals(input string tag);
      chk({tag, "_grant"}, grant, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_done_err"}, done_err, 0);
      chk({tag, "_spi_start"}, spi_start, 0);
      chk({tag, "_spi_reset"}, spi_reset, 0);
      chk({tag, "_motor_sel"}, motor_sel, 0);
      chk({tag, "_ss_n_o"}, ss_n_o, {NM{1'b1}});
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_timeout_count"}, timeout_count, 0);
      chk({tag, "_frame_count"}, frame_count, 0);
   endtask

   // plan: 0 = normal frame (fall/rise cycles after start), 1 = spi_done held
   // low, 2 = spi_done stuck high. abort_at != 0 applies reset at that cycle.
   // mut drops req and scrambles req_motor mid-frame.
   task automatic frame(input logic [NR-1:0] rq, input logic [7:0] m0, input logic [7:0] m1,
                        input int plan, input int fall, input int rise,
                        input int abort_at, input bit mut);
      int g;
      int m;
      int td;
      int exp_td;
      bit bad;
      bit to;
      logic [NM-1:0] ex_ss;
      logic [7:0] mot [NR];
      exp_t e;
      mot[0] = m0;
      mot[1] = m1;
      g = -1;
      for (int k = 0; k < NR; k++) begin
         int i;
         i = (m_ptr + k) % NR;
         if (g < 0 && rq[i]) g = i;
      end
      m      = int'(mot[g]);
      bad    = (m >= NM);
      to     = !bad && (plan != 0);
      exp_td = bad ? 0 : ((plan == 0) ? rise + 1 : TO + 1);
      e.g    = g;
      e.err  = bad || to;
      sb.push_back(e);
      chk("idle_before_frame", busy, 0);
      req       = rq;
      req_motor = {m1, m0};
      td        = -1;
      tick();
      for (int t = 0; t <= TO + 5 && td < 0; t++) begin
         if (t >= 1 && !bad) begin
            if (plan == 0) begin
               spi_done = !(t >= fall && t < rise);
               ss_n     = !(t >= fall && t < rise);
            end else if (plan == 1) begin
               spi_done = 1'b0;
               ss_n     = 1'b0;
            end else begin
               spi_done = 1'b1;
               ss_n     = 1'b1;
            end
         end
         if (mut && t == 3) begin
            req       = '0;
            req_motor = {~m1, ~m0};
         end
         if (abort_at != 0 && t == abort_at) begin
            reset = 1'b1;
            req   = '0;
            tick();
            reset    = 1'b0;
            spi_done = 1'b1;
            ss_n     = 1'b1;
            #1;
            reset_vals("abort");
            void'(sb.pop_back());
            m_ptr    = 0;
            m_frames = 0;
            m_tos    = 0;
            return;
         end
         #1;
         chk("spi_start", spi_start, !bad && t == 0);
         chk("grant", grant, 64'(1) << g);
         chk("busy", busy, 1);
         chk("motor_sel", motor_sel, m);
         chk("spi_reset", spi_reset, to && t == TO);
         ex_ss = '1;
         if (!bad) ex_ss[m] = ss_n;
         chk("ss_n_o", ss_n_o, ex_ss);
         if (done !== '0) td = t;
         else tick();
      end
      chk("done_time", td, exp_td);
      m_frames++;
      if (to && m_tos < 65535) m_tos++;
      m_ptr    = (g + 1) % NR;
      spi_done = 1'b1;
      ss_n     = 1'b1;
      tick();
      chk("idle_after_frame", busy, 0);
      chk("grant_cleared", grant, 0);
      chk("frame_count", frame_count, m_frames);
      chk("timeout_count", timeout_count, m_tos);
   endtask

   initial begin
      #500000;
      $display("FAIL global_time_limit reached at %0t", $time);
      $fatal(1);
   end

   initial begin
      logic [NR-1:0] rq;
      logic [7:0] r0;
      logic [7:0] r1;
      int pl;
      int fa;
      int ri;
      reset     = 1'b1;
      req       = '0;
      req_motor = '0;
      spi_done  = 1'b1;
      ss_n      = 1'b1;
      repeat (3) tick();
      reset_vals("por");
      reset = 1'b0;
      tick();
      reset_vals("idle");

      // single request, motor 3, fall at +5, rise at +40
      frame(2'b01, 8'd3, 8'd0, 0, 5, 40, 0, 1'b0);
      // requester 1 wins (pointer 1); reset in WAIT_HIGH aborts the frame
      frame(2'b11, 8'd2, 8'd4, 0, 5, 40, 10, 1'b0);
      // contention after reset: pointer back to 0, grants 0,1,0,1
      for (int i = 0; i < 4; i++) begin
         frame(2'b11, 8'(i), 8'(5 - i), 0, 2 + i, 20 + i, 0, 1'b0);
      end
      req = '0;
      // invalid motor index for requester 1
      frame(2'b10, 8'd0, 8'd8, 0, 0, 0, 0, 1'b0);
      req = '0;
      // timeout with spi_done held low
      frame(2'b01, 8'd1, 8'd0, 1, 0, 0, 0, 1'b0);
      req = '0;
      // timeout with spi_done stuck high
      frame(2'b01, 8'd5, 8'd0, 2, 0, 0, 0, 1'b0);
      req = '0;
      // rise on the watchdog expiry cycle counts as success
      frame(2'b10, 8'd0, 8'd4, 0, 5, TO, 0, 1'b0);
      req = '0;
      // req dropped and req_motor changed mid-frame
      frame(2'b11, 8'd2, 8'd3, 0, 3, 30, 0, 1'b1);
      req = '0;

      for (int n = 0; n < 30; n++) begin
         rq = NR'($urandom_range(1, 3));
         r0 = 8'($urandom_range(0, 7));
         r1 = 8'($urandom_range(0, 7));
         fa = $urandom_range(1, 20);
         ri = fa + $urandom_range(1, 60);
         pl = $urandom_range(0, 9);
         if (pl <= 6) frame(rq, r0, r1, 0, fa, ri, 0, $urandom_range(0, 4) == 0);
         else if (pl == 7) frame(rq, r0, r1, 1, 0, 0, 0, 1'b0);
         else if (pl == 8) frame(rq, r0, r1, 2, 0, 0, 0, 1'b0);
         else frame(rq, r0, r1, 0, fa, TO, 0, 1'b0);
         if ($urandom_range(0, 1) == 1) begin
            req = '0;
            repeat ($urandom_range(1, 4)) tick();
         end
      end
      req = '0;
      repeat (5) tick();
      chk("scoreboard_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
